alu_arbiter: RTL

- Shares one combinational 16-bit ALU between two requesters (port 0, port 1).
- Round-robin arbitration, valid/ready handshakes on request and response sides.
- Operands and opcode are registered and driven onto the ALU. Result and flags are captured after a configurable settle time.
- Sits between the issuing units and the `alu` instance. The ALU's a/b/opcode inputs are driven only by this block.

---
 rtl/alu_arbiter_if.sv | 51 +++++
 rtl/alu_arbiter.sv | 97 +++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Signal bundle between alu_arbiter, its two requesters and the shared ALU.
// The slave modport is the arbiter's view; master is the surrounding system.
interface alu_arbiter_if #(
    parameter int DATA_W = 16
);
    logic              req_valid_0;
    logic              req_ready_0;
    logic [DATA_W-1:0] req_a_0;
    logic [DATA_W-1:0] req_b_0;
    logic [2:0]        req_op_0;
    logic              req_valid_1;
    logic              req_ready_1;
    logic [DATA_W-1:0] req_a_1;
    logic [DATA_W-1:0] req_b_1;
    logic [2:0]        req_op_1;
    logic              resp_valid_0;
    logic              resp_ready_0;
    logic              resp_valid_1;
    logic              resp_ready_1;
    logic [DATA_W:0]   resp_o;
    logic [3:0]        resp_flags;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_op;
    logic [DATA_W:0]   alu_o;
    logic              alu_s;
    logic              alu_c;
    logic              alu_p;
    logic              alu_z;
    logic              busy;

    modport slave (
        input  req_valid_0, req_a_0, req_b_0, req_op_0,
        input  req_valid_1, req_a_1, req_b_1, req_op_1,
        input  resp_ready_0, resp_ready_1,
        input  alu_o, alu_s, alu_c, alu_p, alu_z,
        output req_ready_0, req_ready_1,
        output resp_valid_0, resp_valid_1, resp_o, resp_flags,
        output alu_a, alu_b, alu_op, busy
    );

    modport master (
        output req_valid_0, req_a_0, req_b_0, req_op_0,
        output req_valid_1, req_a_1, req_b_1, req_op_1,
        output resp_ready_0, resp_ready_1,
        output alu_o, alu_s, alu_c, alu_p, alu_z,
        input  req_ready_0, req_ready_1,
        input  resp_valid_0, resp_valid_1, resp_o, resp_flags,
        input  alu_a, alu_b, alu_op, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters,
// with registered operands and a result captured after ALU_LAT settle cycles.
module alu_arbiter #(
    parameter int DATA_W  = 16,
    parameter int ALU_LAT = 1
) (
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave bus
);
    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state;
    logic              grant;
    logic              last_grant;
    logic              pick;
    logic              any_valid;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [2:0]        op_code;
    logic [DATA_W:0]   result;
    logic [3:0]        flags;
    logic              valid_0;
    logic              valid_1;

    // When both ports ask, the one not served last wins.
    always_comb begin
        any_valid = bus.req_valid_0 | bus.req_valid_1;
        pick      = (bus.req_valid_0 && bus.req_valid_1) ? ~last_grant : bus.req_valid_1;
    end

    assign bus.req_ready_0  = (state == IDLE) && any_valid && !pick;
    assign bus.req_ready_1  = (state == IDLE) && any_valid && pick;
    assign bus.resp_valid_0 = valid_0;
    assign bus.resp_valid_1 = valid_1;
    assign bus.resp_o       = result;
    assign bus.resp_flags   = flags;
    assign bus.alu_a        = op_a;
    assign bus.alu_b        = op_b;
    assign bus.alu_op       = op_code;
    assign bus.busy         = (state != IDLE);

    // RESP spends one cycle raising resp_valid, so the response is flagged
    // ALU_LAT+1 edges after acceptance with the captured result already stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_code    <= '0;
            result     <= '0;
            flags      <= '0;
            valid_0    <= 1'b0;
            valid_1    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant   <= pick;
                        op_a    <= pick ? bus.req_a_1  : bus.req_a_0;
                        op_b    <= pick ? bus.req_b_1  : bus.req_b_0;
                        op_code <= pick ? bus.req_op_1 : bus.req_op_0;
                        cnt     <= CNT_W'(ALU_LAT - 1);
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        result <= bus.alu_o;
                        flags  <= {bus.alu_s, bus.alu_c, bus.alu_p, bus.alu_z};
                        state  <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (!(valid_0 || valid_1)) begin
                        valid_0 <= !grant;
                        valid_1 <= grant;
                    end else if (grant ? bus.resp_ready_1 : bus.resp_ready_0) begin
                        valid_0    <= 1'b0;
                        valid_1    <= 1'b0;
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
